// File: rtl/riscv_pkg.sv
// Shared constants and types for the ID/EX stage: ALU op codes, major opcodes
// and the write-back/memory control bundle carried alongside the operands.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b1010;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic illegal;
  } ex_ctrl_t;

  // x0 is hardwired to zero, so a write to it is suppressed.
  function automatic logic rd_writable(input logic [REG_ADDR_W-1:0] rd);
    return (rd != {REG_ADDR_W{1'b0}});
  endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// Decode -> ID/EX -> execute handshake bundle. master = decode/downstream side,
// slave = the ID/EX stage itself.
interface id_ex_stage_if;
  import riscv_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [6:0]            in_opcode;
  logic [2:0]            in_funct3;
  logic                  in_funct7_5;
  logic [XLEN-1:0]       in_rs1_data;
  logic [XLEN-1:0]       in_rs2_data;
  logic [XLEN-1:0]       in_imm;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [XLEN-1:0]       in_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       alu_a;
  logic [XLEN-1:0]       alu_b;
  logic [3:0]            alu_op;
  logic [XLEN-1:0]       out_rs2_data;
  logic [REG_ADDR_W-1:0] out_rd;
  logic [XLEN-1:0]       out_pc;
  logic                  out_reg_write;
  logic                  out_mem_read;
  logic                  out_mem_write;
  logic                  out_branch;
  logic                  out_illegal;

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7_5, in_rs1_data, in_rs2_data,
           in_imm, in_rd, in_pc, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_op, out_rs2_data, out_rd, out_pc,
           out_reg_write, out_mem_read, out_mem_write, out_branch, out_illegal
  );

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7_5, in_rs1_data, in_rs2_data,
           in_imm, in_rd, in_pc, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_op, out_rs2_data, out_rd, out_pc,
           out_reg_write, out_mem_read, out_mem_write, out_branch, out_illegal
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct3/funct7[5] -> ALU op and control decode.
// Any unsupported encoding collapses to illegal with every enable cleared.
module alu_ctrl_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_op_o,
  output logic       use_imm_o,
  output logic       reg_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       branch_o,
  output logic       illegal_o
);
  logic [3:0] op_s;
  logic       imm_s;
  logic       rw_s;
  logic       mr_s;
  logic       mw_s;
  logic       br_s;
  logic       bad_s;

  // Classify the encoding, then mask everything if it turned out illegal.
  always_comb begin
    op_s  = ALU_AND;
    imm_s = 1'b0;
    rw_s  = 1'b0;
    mr_s  = 1'b0;
    mw_s  = 1'b0;
    br_s  = 1'b0;
    bad_s = 1'b0;
    case (opcode_i)
      OP_R, OP_IMM: begin
        imm_s = (opcode_i == OP_IMM);
        rw_s  = 1'b1;
        case (funct3_i)
          3'b000: begin
            if (funct7_5_i && (opcode_i == OP_R)) begin
              op_s = ALU_SUB;
            end else begin
              op_s = ALU_ADD;
            end
          end
          3'b111: op_s = ALU_AND;
          3'b110: op_s = ALU_OR;
          3'b101: begin
            if (funct7_5_i) begin
              bad_s = 1'b1;
            end else begin
              op_s = ALU_SRL;
            end
          end
          default: bad_s = 1'b1;
        endcase
      end
      OP_LOAD: begin
        op_s  = ALU_ADD;
        imm_s = 1'b1;
        mr_s  = 1'b1;
        rw_s  = 1'b1;
        bad_s = (funct3_i != 3'b010);
      end
      OP_STORE: begin
        op_s  = ALU_ADD;
        imm_s = 1'b1;
        mw_s  = 1'b1;
        bad_s = (funct3_i != 3'b010);
      end
      OP_BRANCH: begin
        op_s  = ALU_SUB;
        br_s  = 1'b1;
        bad_s = (funct3_i != 3'b000);
      end
      default: bad_s = 1'b1;
    endcase

    if (bad_s) begin
      alu_op_o    = ALU_AND;
      use_imm_o   = 1'b0;
      reg_write_o = 1'b0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      branch_o    = 1'b0;
      illegal_o   = 1'b1;
    end else begin
      alu_op_o    = op_s;
      use_imm_o   = imm_s;
      reg_write_o = rw_s;
      mem_read_o  = mr_s;
      mem_write_o = mw_s;
      branch_o    = br_s;
      illegal_o   = 1'b0;
    end
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-deep valid/ready skid-free stage feeding the ALU,
// with synchronous flush for branch redirects.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  id_ex_stage_if.slave  bus
);
  logic [3:0] dec_op_s;
  logic       dec_imm_s;
  ex_ctrl_t   dec_ctrl_s;

  alu_ctrl_decode u_dec (
    .opcode_i    (bus.in_opcode),
    .funct3_i    (bus.in_funct3),
    .funct7_5_i  (bus.in_funct7_5),
    .alu_op_o    (dec_op_s),
    .use_imm_o   (dec_imm_s),
    .reg_write_o (dec_ctrl_s.reg_write),
    .mem_read_o  (dec_ctrl_s.mem_read),
    .mem_write_o (dec_ctrl_s.mem_write),
    .branch_o    (dec_ctrl_s.branch),
    .illegal_o   (dec_ctrl_s.illegal)
  );

  logic                  valid_q, valid_d;
  logic [XLEN-1:0]       alu_a_q, alu_a_d;
  logic [XLEN-1:0]       alu_b_q, alu_b_d;
  logic [3:0]            alu_op_q, alu_op_d;
  logic [XLEN-1:0]       rs2_q, rs2_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  ex_ctrl_t              ctrl_q, ctrl_d;
  logic                  in_ready_s;
  logic                  accept_s;

  assign in_ready_s = ~flush & (~valid_q | bus.out_ready);
  assign accept_s   = bus.in_valid & in_ready_s;

  // Next-state: flush beats accept beats drain; otherwise hold.
  always_comb begin
    valid_d  = valid_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    pc_d     = pc_q;
    ctrl_d   = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d          = 1'b1;
      alu_a_d          = bus.in_rs1_data;
      alu_b_d          = dec_imm_s ? bus.in_imm : bus.in_rs2_data;
      alu_op_d         = dec_op_s;
      rs2_d            = bus.in_rs2_data;
      rd_d             = bus.in_rd;
      pc_d             = bus.in_pc;
      ctrl_d           = dec_ctrl_s;
      ctrl_d.reg_write = dec_ctrl_s.reg_write & rd_writable(bus.in_rd);
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Stage register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      alu_a_q  <= {XLEN{1'b0}};
      alu_b_q  <= {XLEN{1'b0}};
      alu_op_q <= ALU_AND;
      rs2_q    <= {XLEN{1'b0}};
      rd_q     <= {REG_ADDR_W{1'b0}};
      pc_q     <= {XLEN{1'b0}};
      ctrl_q   <= '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    end else begin
      valid_q  <= valid_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      pc_q     <= pc_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign bus.in_ready      = in_ready_s;
  assign bus.out_valid     = valid_q;
  assign bus.alu_a         = alu_a_q;
  assign bus.alu_b         = alu_b_q;
  assign bus.alu_op        = alu_op_q;
  assign bus.out_rs2_data  = rs2_q;
  assign bus.out_rd        = rd_q;
  assign bus.out_pc        = pc_q;
  assign bus.out_reg_write = ctrl_q.reg_write;
  assign bus.out_mem_read  = ctrl_q.mem_read;
  assign bus.out_mem_write = ctrl_q.mem_write;
  assign bus.out_branch    = ctrl_q.branch;
  assign bus.out_illegal   = ctrl_q.illegal;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/execute pipeline stage that sits directly upstream of the ALU.
- Accepts one decoded instruction per cycle from the decode stage over a valid/ready handshake.
- Translates opcode/funct3/funct7[5] into the 4-bit ALU operation code and selects operand B (rs2 or immediate).
- Registers the result, driving the ALU A/B/op inputs and the write-back control to the next stage.

Parameters:
- XLEN, 32, datapath width of the operand, immediate and pc fields.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of the held instruction (branch redirect).
- in_valid  input  1  decode stage presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_opcode  input  7  instruction[6:0].
- in_funct3  input  3  instruction[14:12].
- in_funct7_5  input  1  instruction[30].
- in_rs1_data  input  XLEN  register-file read port 1.
- in_rs2_data  input  XLEN  register-file read port 2.
- in_imm  input  XLEN  sign-extended immediate from decode.
- in_rd  input  REG_ADDR_W  destination register.
- in_pc  input  XLEN  instruction address.
- out_valid  output  1  registered instruction is valid.
- out_ready  input  1  downstream (EX/MEM) accepts.
- alu_a  output  XLEN  to ALU A.
- alu_b  output  XLEN  to ALU B (rs2 or imm).
- alu_op  output  4  to ALU ALUOp.
- out_rs2_data  output  XLEN  store data.
- out_rd  output  REG_ADDR_W  destination register.
- out_pc  output  XLEN  pc passthrough.
- out_reg_write  output  1  write-back enable.
- out_mem_read  output  1  load.
- out_mem_write  output  1  store.
- out_branch  output  1  beq; ALU zero decides.
- out_illegal  output  1  unsupported encoding.

Behaviour:
- Reset (rst_n low, asynchronous): all registered outputs are 0, and alu_op = 4'b0000. Release is synchronous to clk.
- Handshake:
  - in_ready = ~out_valid | out_ready (combinational). No combinational in→out data path.
  - A transfer occurs when in_valid & in_ready. All fields load at the next clk edge and out_valid is set to 1. Latency is 1 cycle.
  - Held state: out_valid & ~out_ready holds every output stable and in_ready = 0.
  - Drain: out_valid & out_ready & ~in_valid sets out_valid to 0 next cycle. Data outputs may hold stale values.
  - Simultaneous accept and drain: the new instruction replaces the old one with no bubble, giving full throughput.
- Flush:
  - Next cycle out_valid = 0 and in_ready is forced to 0 for that cycle, so no accept occurs.
  - Flush has priority over accept and over hold.
- Decode (combinational, registered with the data):
  - R-type 0110011:
    - f3=000, f7_5=0: add, op 0010.
    - f3=000, f7_5=1: sub, op 0110.
    - f3=111: and, op 0000.
    - f3=110: or, op 0001.
    - f3=101, f7_5=0: srl, op 1010.
    - B=rs2, reg_write=1.
  - I-ALU 0010011:
    - addi 000 → 0010; andi 111 → 0000; ori 110 → 0001; srli 101 with f7_5=0 → 1010.
    - B=imm, reg_write=1.
  - Load 0000011, f3=010: add, B=imm, mem_read=1, reg_write=1.
  - Store 0100011, f3=010: add, B=imm, mem_write=1.
  - Branch 1100011, f3=000: sub, B=rs2, branch=1.
  - Anything else:
    - illegal=1, alu_op=0000, all enables 0.
    - The instruction still transfers with valid=1 so downstream can trap.
- rd = x0 forces reg_write=0.
- alu_a is always rs1_data.
- Immediate is used as given; no re-extension. srli shift amount is the ALU's B[4:0].
- Reset asserted mid-hold discards the instruction: out_valid=0 immediately.

Decomposition:
- Package riscv_pkg:
  - ALU op localparams: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_SRL=1010.
  - Opcode localparams: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH.
- One combinational sub-module, alu_ctrl_decode: inputs opcode, funct3, funct7_5; outputs alu_op, use_imm, reg_write, mem_read, mem_write, branch, illegal.
- id_ex_stage holds the register bank and the handshake.

Test Plan:
- Reset: rst_n=0 with in_valid=1 → out_valid=0, alu_op=0000, in_ready=1. Release, then push sub x3,x1,x2 (rs1=10, rs2=3) → next cycle out_valid=1, alu_op=0110, alu_a=10, alu_b=3, reg_write=1, rd=3.
- Immediates: addi rd=5 with imm=-4 (0xFFFFFFFC) → alu_op=0010, alu_b=0xFFFFFFFC. srli f7_5=0 imm=4 → alu_op=1010, alu_b=4.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs frozen. out_ready=1 → the next instruction appears the following cycle, with none lost or duplicated.
- Streaming: 8 back-to-back instructions with out_ready=1 → 8 consecutive out_valid cycles in order, and in_ready stays 1.
- Flush: flush with out_valid=1 and in_valid=1 → next cycle out_valid=0, and that input is not taken (in_ready=0 during flush).
- Illegal and x0:
  - opcode 1110011 → out_illegal=1, reg_write=0, out_valid=1.
  - add x0,x1,x2 → reg_write=0.
  - sw f3=010 → mem_write=1, alu_op=0010, alu_b=imm, out_rs2_data=rs2.
